// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared state encoding and 2-input gate truth tables for truth-table checkers
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_XNOR2 = 4'b1001;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: sweeps all input vectors into a gate, samples its output after a settle time and scores it against a truth table
module gate_tt_checker
    import gate_test_pkg::*;
#(
    parameter int                 N_IN   = 2,
    parameter logic [2**N_IN-1:0] EXP_TT = TT_XNOR2,
    parameter int                 SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec
);

    localparam int              CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST    = '1;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic            w_go, w_mis;

    // start is only honoured between sweeps; dut_y only matters in SAMPLE
    assign w_go  = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_mis = (r_state == SAMPLE) && (dut_y != EXP_TT[stim]);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state: hold each vector SETTLE cycles, then sample once
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = start ? DRIVE : r_state;
            DRIVE:      w_next = (r_cnt == CNT_MAX) ? SAMPLE : DRIVE;
            SAMPLE:     w_next = (stim == LAST) ? DONE : DRIVE;
            default:    w_next = IDLE;
        endcase
    end

    // datapath: vector sequencing, settle count and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim          <= '0;
            r_cnt         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
        end else if (w_go) begin
            stim          <= '0;
            r_cnt         <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
        end else if (r_state == DRIVE) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
        end else if (r_state == SAMPLE) begin
            if (w_mis) begin
                err_count <= err_count + (N_IN+1)'(1);
                if (~|err_count) first_err_vec <= stim;
            end
            if (stim == LAST) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= ~|err_count && !w_mis;
            end else begin
                stim  <= stim + N_IN'(1);
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Hardware truth-table checker: the response end of a gate test.
- On `start`, sweeps every input vector into a combinational gate under test, waits a settle time, samples the gate output and compares it with an expected truth table.
- Reports pass/fail, the mismatch count and the first failing vector.
- Used for self-test of the library's basic gates (XNOR by default) in simulation and on FPGA.

Parameters:
- N_IN, 2, number of gate inputs; the sweep covers 2^N_IN vectors.
- EXP_TT, 4'b1001, expected output table, width 2^N_IN; bit i = expected y for input vector i (default = XNOR).
- SETTLE, 2, cycles `stim` is held before sampling; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; level-sampled, honoured only in IDLE or DONE.
- stim  out  N_IN  input vector driven to the gate under test.
- dut_y  in  1  gate-under-test output (combinational from `stim`).
- busy  out  1  high while a sweep is in progress.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors in the last sweep.
- first_err_vec  out  N_IN  first failing vector; valid when err_count!=0.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - state=IDLE.
  - stim=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, settle counter=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge → DRIVE; stim=0, err_count=0, first_err_vec=0, settle cnt=0, busy=1.
  - start=0 → stay in IDLE.
- DRIVE:
  - stim held.
  - If cnt==SETTLE-1 → SAMPLE; else cnt+1.
- SAMPLE:
  - Compare dut_y against EXP_TT[stim].
  - On mismatch: err_count+1; if err_count was 0, first_err_vec=stim.
  - If stim==2^N_IN-1 → DONE: busy=0, done=1, pass=(final err_count==0).
  - Otherwise stim+1, cnt=0 → DRIVE.
- DONE:
  - All results and stim held.
  - start=1 → same actions as IDLE start (done=0, pass=0, counters cleared) → DRIVE.
- Latency:
  - Each vector occupies SETTLE+1 cycles.
  - done rises 2^N_IN*(SETTLE+1) edges after the edge that samples start. Defaults: 12.
- Ordering: vectors are applied in ascending order 0..2^N_IN-1. stim never skips or repeats within a sweep.
- Boundaries:
  - start during DRIVE/SAMPLE is ignored; the sweep is not restarted.
  - start held high continuously → back-to-back sweeps, with a one-cycle DONE between them.
  - err_count max = 2^N_IN; the width N_IN+1 means no wrap.
  - The mismatch on vector 0 sets first_err_vec=0; distinguish "no error" via err_count.
  - Reset mid-sweep → immediate return to reset values; no partial result retained.
  - dut_y is sampled only in SAMPLE; glitches during DRIVE are ignored.
- All outputs are registered; no combinational path from dut_y to any output.

Decomposition:
- Shared package gate_test_pkg holds:
  - state encoding constants (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - truth-table constants TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110, TT_XNOR2=4'b1001, TT_NAND2=4'b0111, TT_NOR2=4'b0001.
- Single module; the settle counter stays inline (too small for a sub-module).
- The bench instantiates gate_tt_checker with an existing gate model (e.g. XNOR switch-level) as the gate under test.

Test Plan:
- Correct XNOR DUT, defaults, start pulse 1 cycle:
  - stim sequence 0,1,2,3, each held 3 cycles.
  - done=1 12 edges after start; pass=1, err_count=0.
- Stuck-at-0 DUT:
  - err_count=2 (vectors 0 and 3 fail), first_err_vec=0, pass=0.
- XOR DUT against XNOR table:
  - err_count=4, first_err_vec=0, pass=0.
- DUT wrong only at vector 2'b10:
  - err_count=1, first_err_vec=2, pass=0.
- start re-pulsed during DRIVE of vector 1:
  - Ignored; sweep completes at the original cycle.
  - Then start in DONE: done drops next edge, err_count cleared, new sweep runs.
- rst_n low during SAMPLE of vector 2:
  - All outputs 0 immediately (asynchronous).
  - After release, stays IDLE until start; the next sweep gives correct results.
